// File: rtl/xregbank_arb.sv
// Round-robin arbiter that serialises single-word read/write transactions from
// NREQ requesters onto an external bank of NREG registers (enable/D out, Q in).
module xregbank_arb #(
    parameter int DATA_W = 32,
    parameter int N      = DATA_W,
    parameter int NREQ   = 4,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*N-1:0]      wdata,
    output logic [NREQ-1:0]        ack,
    output logic [N-1:0]           rdata,
    output logic [NREG-1:0]        reg_en,
    output logic [N-1:0]           reg_d,
    input  logic [NREG*N-1:0]      reg_q,
    output logic                   dbg_state
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Handshake: a requester holds req/we/addr/wdata stable until its ack
    // pulse; ack lasts one cycle, and req seen high in the following IDLE
    // cycle is a new transaction.
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREG-1:0]   reg_en_q, reg_en_d;
    logic [N-1:0]      reg_d_q, reg_d_d;
    logic [N-1:0]      rdata_q, rdata_d;

    logic              found;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [N-1:0]      sel_wdata;
    logic [NREG-1:0]   addr_oh;
    logic [N-1:0]      rd_word;

    // Winner search and decode of the winner's address; an address with no
    // matching register yields an all-zero strobe and zero read data.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        sel_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_wdata = wdata[int'(sel)*N +: N];
        addr_oh   = '0;
        rd_word   = '0;
        for (int k = 0; k < NREG; k++) begin
            if (sel_addr == ADDR_W'(k)) begin
                addr_oh[k] = 1'b1;
                rd_word    = reg_q[k*N +: N];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        ack_d    = ack_q;
        reg_en_d = reg_en_q;
        reg_d_d  = reg_d_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = EXEC;
                    win_d      = sel;
                    ack_d      = '0;
                    ack_d[sel] = 1'b1;
                    if (we[sel]) begin
                        reg_en_d = addr_oh;
                        reg_d_d  = sel_wdata;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            EXEC: begin
                state_d  = IDLE;
                ack_d    = '0;
                reg_en_d = '0;
                ptr_d    = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            ack_q    <= '0;
            reg_en_q <= '0;
            reg_d_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            ack_q    <= ack_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign reg_en    = reg_en_q;
    assign reg_d     = reg_d_q;
    assign dbg_state = (state_q == EXEC);

endmodule

// File: tb/tb_xregbank_arb.sv
// Directed bench for xregbank_arb: an 8-register bank on the main instance and
// a 6-register bank (3-bit address) on a second instance for out-of-range cases.
module tb_xregbank_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Main instance: NREG=8
    logic [3:0]   req = '0, we = '0;
    logic [11:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [3:0]   ack;
    logic [31:0]  rdata, reg_d;
    logic [7:0]   reg_en;
    logic [255:0] reg_q;
    logic         dbg_state;
    logic [31:0]  bank [8];

    xregbank_arb #(.N(32), .NREQ(4), .NREG(8), .ADDR_W(3)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .reg_en(reg_en), .reg_d(reg_d), .reg_q(reg_q),
        .dbg_state(dbg_state)
    );

    // Second instance: NREG=6 with a 3-bit address
    logic [3:0]   s_req = '0, s_we = '0;
    logic [11:0]  s_addr = '0;
    logic [127:0] s_wdata = '0;
    logic [3:0]   s_ack;
    logic [31:0]  s_rdata, s_reg_d;
    logic [5:0]   s_reg_en;
    logic [191:0] s_reg_q;
    logic         s_dbg_state;
    logic [31:0]  s_bank [6];

    xregbank_arb #(.N(32), .NREQ(4), .NREG(6), .ADDR_W(3)) u_small (
        .clk(clk), .rst(rst), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata),
        .ack(s_ack), .rdata(s_rdata), .reg_en(s_reg_en), .reg_d(s_reg_d), .reg_q(s_reg_q),
        .dbg_state(s_dbg_state)
    );

    // Register bank models: reset has priority over enable
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (rst) bank[k] <= '0;
            else if (reg_en[k]) bank[k] <= reg_d;
        end
        for (int k = 0; k < 6; k++) begin
            if (rst) s_bank[k] <= '0;
            else if (s_reg_en[k]) s_bank[k] <= s_reg_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) reg_q[k*32 +: 32] = bank[k];
        for (int k = 0; k < 6; k++) s_reg_q[k*32 +: 32] = s_bank[k];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic w, input logic [2:0] a, input logic [31:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*3 +: 3]   = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic s_drive(input logic w, input logic [2:0] a, input logic [31:0] d);
        s_req[0]      = 1'b1;
        s_we[0]       = w;
        s_addr[2:0]   = a;
        s_wdata[31:0] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({ack, reg_en, reg_d, rdata, dbg_state} !== 77'd0)
                $display("FAIL reset_idle cycle %0d: ack=%b reg_en=%b reg_d=%h rdata=%h state=%b, expected all 0",
                         c, ack, reg_en, reg_d, rdata, dbg_state);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        drive(1, 1'b1, 3'd5, 32'hDEADBEEF);
        tick();
        n_checks++;
        if (ack !== 4'b0010 || reg_en !== 8'b0010_0000 || reg_d !== 32'hDEADBEEF || dbg_state !== 1'b1)
            $display("FAIL wr_exec: ack=%b reg_en=%b reg_d=%h state=%b, expected 0010 00100000 deadbeef 1",
                     ack, reg_en, reg_d, dbg_state);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if (ack !== 4'b0000 || reg_en !== 8'd0 || reg_d !== 32'hDEADBEEF)
            $display("FAIL wr_done: ack=%b reg_en=%b reg_d=%h, expected 0000 0 deadbeef (held)", ack, reg_en, reg_d);
        else n_pass++;
        drive(2, 1'b0, 3'd5, 32'h0);
        tick();
        n_checks++;
        if (ack !== 4'b0100 || rdata !== 32'hDEADBEEF || reg_en !== 8'd0)
            $display("FAIL rd_after_wr: ack=%b rdata=%h reg_en=%b, expected 0100 deadbeef 0", ack, rdata, reg_en);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_reset_exec();
        drive(1, 1'b1, 3'd4, 32'h12345678);
        tick();
        n_checks++;
        if (ack !== 4'b0010 || reg_en !== 8'b0001_0000 || rdata !== 32'hDEADBEEF)
            $display("FAIL rst_pre: ack=%b reg_en=%b rdata=%h, expected 0010 00010000 deadbeef", ack, reg_en, rdata);
        else n_pass++;
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ack, reg_en, reg_d, rdata, dbg_state} !== 77'd0)
            $display("FAIL rst_exec: ack=%b reg_en=%b reg_d=%h rdata=%h state=%b, expected all 0",
                     ack, reg_en, reg_d, rdata, dbg_state);
        else n_pass++;
        drive(2, 1'b1, 3'd4, 32'h0BADF00D);
        tick();
        n_checks++;
        if (ack !== 4'b0100 || reg_en !== 8'b0001_0000 || reg_d !== 32'h0BADF00D)
            $display("FAIL rst_after_wr: ack=%b reg_en=%b reg_d=%h, expected 0100 00010000 0badf00d", ack, reg_en, reg_d);
        else n_pass++;
        req = '0;
        tick();
        drive(3, 1'b0, 3'd4, 32'h0);
        tick();
        n_checks++;
        if (ack !== 4'b1000 || rdata !== 32'h0BADF00D)
            $display("FAIL rst_after_rd: ack=%b rdata=%h, expected 1000 0badf00d", ack, rdata);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 3'(i), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = 4'b0000;
            if (k % 2 == 1) exp[((k - 1) / 2) % 4] = 1'b1;
            n_checks++;
            if (ack !== exp)
                $display("FAIL rr_order tick %0d: ack=%b, expected %b", k, ack, exp);
            else n_pass++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_contention();
        // ptr is 2 after the round-robin run ended on requester 1
        drive(3, 1'b0, 3'd0, 32'h0);
        tick();
        n_checks++;
        if (ack !== 4'b1000)
            $display("FAIL cont_first: ack=%b, expected 1000", ack);
        else n_pass++;
        drive(0, 1'b1, 3'd2, 32'h11111111);
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b0001 || reg_en !== 8'b0000_0100 || reg_d !== 32'h11111111)
            $display("FAIL cont_wrap: ack=%b reg_en=%b reg_d=%h, expected 0001 00000100 11111111", ack, reg_en, reg_d);
        else n_pass++;
        req[0] = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b1000)
            $display("FAIL cont_wait: ack=%b, expected 1000", ack);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_out_of_range();
        s_drive(1'b1, 3'd3, 32'hA5A5A5A5);
        tick();
        s_req = '0;
        tick();
        s_drive(1'b0, 3'd3, 32'h0);
        tick();
        n_checks++;
        if (s_ack !== 4'b0001 || s_rdata !== 32'hA5A5A5A5)
            $display("FAIL oor_preload: ack=%b rdata=%h, expected 0001 a5a5a5a5", s_ack, s_rdata);
        else n_pass++;
        s_req = '0;
        tick();
        s_drive(1'b0, 3'd7, 32'h0);
        tick();
        n_checks++;
        if (s_ack !== 4'b0001 || s_rdata !== 32'h0 || s_reg_en !== 6'd0)
            $display("FAIL oor_read7: ack=%b rdata=%h reg_en=%b, expected 0001 0 0", s_ack, s_rdata, s_reg_en);
        else n_pass++;
        s_req = '0;
        tick();
        s_drive(1'b1, 3'd6, 32'h66666666);
        tick();
        n_checks++;
        if (s_ack !== 4'b0001 || s_reg_en !== 6'd0)
            $display("FAIL oor_write6: ack=%b reg_en=%b, expected 0001 000000", s_ack, s_reg_en);
        else n_pass++;
        s_req = '0;
        tick();
        s_drive(1'b1, 3'd5, 32'h55555555);
        tick();
        n_checks++;
        if (s_ack !== 4'b0001 || s_reg_en !== 6'b10_0000 || s_reg_d !== 32'h55555555)
            $display("FAIL oor_write5: ack=%b reg_en=%b reg_d=%h, expected 0001 100000 55555555", s_ack, s_reg_en, s_reg_d);
        else n_pass++;
        s_req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_exec();
        test_round_robin();
        test_contention();
        test_out_of_range();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xregbank_arb.md
# xregbank_arb

Round-robin arbiter and sequencer that shares one bank of `xregister` instances between several requesters, such as the calculator core, a debug port and peripherals. It serialises single-word read/write transactions, drives each register's `enable`/`D` pins, and returns read data from the registers' `Q` outputs. It sits between the requesters and the register bank; the registers themselves are instantiated outside this block.

## Interface
- `N`, default `DATA_W`: data width of every register.
- `NREQ`, default 4: number of requesters (≥2).
- `NREG`, default 8: number of registers in the bank.
- `ADDR_W`, default 3: register address width; 2^ADDR_W ≥ NREG.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `req`  in  NREQ  per-requester transaction request.
- `we`  in  NREQ  per-requester write (1) / read (0).
- `addr`  in  NREQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `wdata`  in  NREQ*N  flattened write data; requester i uses bits [i*N +: N].
- `ack`  out  NREQ  one-cycle completion pulse, one-hot or zero.
- `rdata`  out  N  read data; valid while the matching `ack` bit is high.
- `reg_en`  out  NREG  register enable strobes, one-hot or zero.
- `reg_d`  out  N  common D bus for all registers.
- `reg_q`  in  NREG*N  flattened register Q outputs; register k uses bits [k*N +: N].

## Operation
- FSM with two states, IDLE and EXEC.
- IDLE:
  - If any `req` is high, select the winner as the first requester with `req` high, scanning from `ptr`, then `ptr`+1, and so on, mod NREQ.
  - Latch the winner index and its `we`, `addr` and `wdata`.
  - For reads, capture `rdata` ← `reg_q[addr]` in the same cycle.
  - Go to EXEC.
  - With no request, stay in IDLE.
- EXEC: lasts exactly one cycle, then returns to IDLE.
  - `ack[winner]`=1.
  - For a write: `reg_en[addr]`=1 and `reg_d`=latched wdata.
  - For a read: `rdata` holds the captured value.
  - `ptr` ← (winner+1) mod NREQ, taking effect from the next IDLE.
- All outputs are registered. Reset values: state IDLE, `ptr` 0, `ack` 0, `reg_en` 0, `reg_d` 0, `rdata` 0.
- `reg_d` holds its last value outside EXEC; `rdata` holds until the next read capture.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until `ack` is seen.
  - Deassert `req` at the edge that ends the `ack` cycle, or keep it high to issue a new request.
  - Losing requesters keep waiting; no request is dropped.
- Out-of-range address (addr ≥ NREG):
  - Write: no `reg_en` bit set.
  - Read: `rdata` = 0.
  - `ack` is still given.
- Fairness: a requester that holds `req` high is served within NREQ transactions.
- Reset mid-EXEC: at the reset edge, state goes to IDLE and all outputs clear. The in-flight write is lost if reset coincides with the EXEC edge; `rst` has priority over `enable` in the registers anyway.

## Timing
- Cycle 0, IDLE: arbitration and latch.
- Cycle 1, EXEC: `ack` and `reg_en` high. The register updates at the edge ending cycle 1.
- Latency from `req` to `ack` is 1 cycle when uncontended. Peak throughput is one transaction per 2 cycles.
- Read-after-write by any requester in the next transaction returns the new value, because the capture happens in IDLE after the register has updated.
- `req` rising during EXEC is considered in the following IDLE cycle only.

## Test plan
- Reset, then idle: all outputs 0 for 10 cycles with `req`=0.
- Requester 1 writes 0xDEADBEEF to addr 5:
  - `ack[1]` high exactly 1 cycle after `req`.
  - `reg_en`=8'b0010_0000 in that cycle.
  - Requester 2 then reads addr 5 and gets `rdata`=0xDEADBEEF with `ack[2]`.
- All 4 requesters hold `req` continuously, starting at `ptr`=0: ack order is 0,1,2,3,0,1; one ack every 2 cycles; never two `ack` bits at once.
- Read from addr 7 with NREG=6: `rdata`=0, `ack` given, `reg_en` stays 0. Write to addr 6 with NREG=6: `reg_en` stays 0.
- Contention after service: requester 3 is served, then requesters 0 and 3 both request; requester 0 wins (`ptr`=0 after wrap).
- `rst` asserted in the EXEC cycle of a write: next cycle `ack`=0, `reg_en`=0, `rdata`=0, state IDLE; a subsequent request is served normally.
